// File: rtl/pdp11_iopage_pkg.sv
// Shared iopage definitions: display/switch register address, serializer state
// encoding and the byte-lane merge used by write-side slaves.
package pdp11_iopage_pkg;

  localparam logic [12:0] DR_ADDR = 13'o17570;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } dr_state_e;

  // Word writes replace everything; byte writes touch only the lane picked by addr[0].
  function automatic logic [15:0] dr_merge(input logic [15:0] cur,
                                           input logic [15:0] wdata,
                                           input logic        byte_op,
                                           input logic        odd);
    logic [15:0] res;
    res = cur;
    if (!byte_op) begin
      res = wdata;
    end else if (odd) begin
      res[15:8] = wdata[15:8];
    end else begin
      res[7:0] = wdata[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/dr_shift_out.sv
// 16-bit MSB-first serializer for a 595-style chain: shift clock, data and a
// latch strobe, each phase lasting CLK_DIV system clocks.
import pdp11_iopage_pkg::*;

module dr_shift_out #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  dr_state_e   state_q;
  logic [7:0]  div_q;
  logic [3:0]  bit_q;
  logic        phase_q;
  logic [15:0] shreg_q;
  logic        busy_q;
  logic        sr_data_q;
  logic        sr_clk_q;
  logic        sr_latch_q;
  logic        div_end_s;

  assign div_end_s = (div_q == DIV_LAST);

  // Frame sequencer; data only moves on the falling shift clock so the chain
  // sees a full phase of setup and hold around each rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bit_q      <= 4'd0;
      phase_q    <= 1'b0;
      shreg_q    <= 16'd0;
      busy_q     <= 1'b0;
      sr_data_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_latch_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q   <= din;
            sr_data_q <= din[15];
            busy_q    <= 1'b1;
            div_q     <= 8'd0;
            bit_q     <= 4'd0;
            phase_q   <= 1'b0;
            sr_clk_q  <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end_s) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= 8'd0;
            if (!phase_q) begin
              phase_q  <= 1'b1;
              sr_clk_q <= 1'b1;
            end else begin
              phase_q  <= 1'b0;
              sr_clk_q <= 1'b0;
              shreg_q  <= {shreg_q[14:0], 1'b0};
              if (bit_q == 4'd15) begin
                bit_q      <= 4'd0;
                sr_data_q  <= 1'b0;
                sr_latch_q <= 1'b1;
                state_q    <= LATCH;
              end else begin
                bit_q     <= bit_q + 4'd1;
                sr_data_q <= shreg_q[14];
              end
            end
          end
        end
        LATCH: begin
          if (!div_end_s) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q      <= 8'd0;
            sr_latch_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          div_q      <= 8'd0;
          bit_q      <= 4'd0;
          phase_q    <= 1'b0;
          busy_q     <= 1'b0;
          sr_data_q  <= 1'b0;
          sr_clk_q   <= 1'b0;
          sr_latch_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign sr_data  = sr_data_q;
  assign sr_clk   = sr_clk_q;
  assign sr_latch = sr_latch_q;

endmodule

// File: rtl/dr_regs.sv
// Display register write slave at 17777570: byte/word capture into the display
// latch, with every new value queued for the front-panel LED shift chain.
import pdp11_iopage_pkg::*;

module dr_regs #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        decode,
  output logic [15:0] display,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch,
  output logic        busy
);

  logic [15:0] display_q, display_d;
  logic        pending_q, pending_d;
  logic        start_s;
  logic        shift_busy_s;
  logic        rd_unused;

  // Reads belong to the switch register sharing this address.
  assign rd_unused = iopage_rd;

  assign decode  = iopage_wr & (iopage_addr[12:1] == DR_ADDR[12:1]);
  assign start_s = pending_q & ~shift_busy_s;

  // A write landing on the load cycle must survive the clear, so set wins.
  always_comb begin
    display_d = display_q;
    pending_d = pending_q;
    if (decode) begin
      display_d = dr_merge(display_q, data_in, iopage_byte_op, iopage_addr[0]);
      pending_d = 1'b1;
    end else if (start_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Pending resets high so the chain is cleared after power-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_q <= 16'd0;
      pending_q <= 1'b1;
    end else begin
      display_q <= display_d;
      pending_q <= pending_d;
    end
  end

  dr_shift_out #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_s),
    .din      (display_q),
    .busy     (shift_busy_s),
    .sr_data  (sr_data),
    .sr_clk   (sr_clk),
    .sr_latch (sr_latch)
  );

  assign display = display_q;
  assign busy    = shift_busy_s;

endmodule

// File: tb/tb_dr_regs.sv
// Directed bench for dr_regs: a negedge monitor records each completed frame
// (bits, rise timing, latch position, length) and the main sequence checks them.
module tb_dr_regs;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] iopage_addr = 13'd0;
  logic [15:0] data_in = 16'd0;
  logic        iopage_rd = 1'b0;
  logic        iopage_wr = 1'b0;
  logic        iopage_byte_op = 1'b0;
  logic        decode;
  logic [15:0] display;
  logic        sr_data, sr_clk, sr_latch, busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] fr_val[$];
  int          fr_lat[$];
  int          fr_len[$];
  logic        fr_ok[$];

  dr_regs #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .iopage_addr(iopage_addr), .data_in(data_in),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .decode(decode), .display(display), .sr_data(sr_data), .sr_clk(sr_clk),
    .sr_latch(sr_latch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: n counts negedges since the posedge that started the frame.
  initial begin : monitor
    bit in_frame = 1'b0;
    int n = 0, nb = 0, lat = -1;
    logic [15:0] bits = 16'd0;
    logic ok = 1'b1, pclk = 1'b0, plat = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (busy) begin
          in_frame = 1'b1; n = 0; nb = 0; lat = -1; bits = 16'd0; ok = 1'b1;
          pclk = sr_clk; plat = sr_latch;
        end
      end else begin
        n++;
        if (sr_clk && !pclk) begin
          if (n != (2 * nb + 1) * CD) ok = 1'b0;
          bits = {bits[14:0], sr_data};
          nb++;
        end
        if (sr_latch && !plat) lat = n;
        pclk = sr_clk; plat = sr_latch;
        if (!busy) begin
          if (nb != 16) ok = 1'b0;
          fr_val.push_back(bits); fr_lat.push_back(lat);
          fr_len.push_back(n);    fr_ok.push_back(ok);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic wait_frames(input int want, input string tag);
    int budget = 600;
    while (fr_val.size() < want && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_arrived"}, 32'(fr_val.size() >= want), 32'd1);
  endtask

  task automatic check_frame(input int idx, input logic [15:0] exp, input string tag);
    if (fr_val.size() > idx) begin
      check({tag, "_bits"},   32'(fr_val[idx]), 32'(exp));
      check({tag, "_latch"},  32'(fr_lat[idx]), 32'd128);
      check({tag, "_len"},    32'(fr_len[idx]), 32'd132);
      check({tag, "_timing"}, 32'(fr_ok[idx]),  32'd1);
    end else begin
      check({tag, "_missing"}, 32'(fr_val.size()), 32'(idx + 1));
    end
  endtask

  // One-cycle write driven at a negedge; leaves the bus idle at the next negedge.
  task automatic bus_wr(input logic [12:0] a, input logic [15:0] d, input logic b,
                        input logic exp_dec, input string tag);
    @(negedge clk);
    iopage_addr = a; data_in = d; iopage_byte_op = b; iopage_wr = 1'b1;
    #1 check({tag, "_decode"}, 32'(decode), 32'(exp_dec));
    @(negedge clk);
    iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    #1 check({tag, "_decode_off"}, 32'(decode), 32'd0);
  endtask

  initial begin
    int base;
    // Reset state
    #12;
    check("rst_display", 32'(display), 32'd0);
    check("rst_outs", {28'd0, busy, sr_clk, sr_data, sr_latch}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Post-reset clearing frame
    wait_frames(1, "f_reset");
    check_frame(0, 16'o000000, "f_reset");

    // Word write
    bus_wr(13'o17570, 16'o123456, 1'b0, 1'b1, "word");
    check("word_display", 32'(display), 32'(16'o123456));
    wait_frames(2, "f_word");
    check_frame(1, 16'b1010011100101110, "f_word");

    // Byte writes starting from zero
    bus_wr(13'o17570, 16'o000000, 1'b0, 1'b1, "zero");
    wait_frames(3, "f_zero");
    check_frame(2, 16'o000000, "f_zero");
    bus_wr(13'o17570, 16'o177777, 1'b1, 1'b1, "blo");
    check("blo_display", 32'(display), 32'(16'o000377));
    wait_frames(4, "f_blo");
    check_frame(3, 16'o000377, "f_blo");
    bus_wr(13'o17571, 16'o125252, 1'b1, 1'b1, "bhi");
    check("bhi_display", 32'(display), 32'(16'o125377));
    wait_frames(5, "f_bhi");
    check_frame(4, 16'o125377, "f_bhi");

    // Other address and a read: no effect
    bus_wr(13'o17572, 16'o070707, 1'b0, 1'b0, "other");
    @(negedge clk);
    iopage_addr = 13'o17570; data_in = 16'o111111; iopage_rd = 1'b1;
    #1 check("read_decode", 32'(decode), 32'd0);
    @(negedge clk); iopage_rd = 1'b0;
    repeat (200) @(negedge clk);
    check("other_display", 32'(display), 32'(16'o125377));
    check("other_noframe", 32'(fr_val.size()), 32'd5);
    check("other_idle", 32'(busy), 32'd0);

    // Coalescing writes during a frame
    bus_wr(13'o17570, 16'o000007, 1'b0, 1'b1, "co7");
    repeat (20) @(negedge clk);
    check("co_busy", 32'(busy), 32'd1);
    bus_wr(13'o17570, 16'o000001, 1'b0, 1'b1, "co1");
    repeat (15) @(negedge clk);
    bus_wr(13'o17570, 16'o000002, 1'b0, 1'b1, "co2");
    bus_wr(13'o17570, 16'o000003, 1'b0, 1'b1, "co3");
    check("co_display", 32'(display), 32'd3);
    wait_frames(7, "f_co");
    check_frame(5, 16'o000007, "f_co_first");
    check_frame(6, 16'o000003, "f_co_second");
    repeat (200) @(negedge clk);
    check("co_single_follow", 32'(fr_val.size()), 32'd7);

    // Write on the load cycle: snapshot is the older value, newer one follows
    @(negedge clk);
    iopage_addr = 13'o17570; data_in = 16'o044444; iopage_wr = 1'b1;
    @(negedge clk);
    data_in = 16'o055555;
    @(negedge clk);
    iopage_wr = 1'b0;
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_display", 32'(display), 32'(16'o055555));
    wait_frames(9, "f_ld");
    check_frame(7, 16'o044444, "f_ld_old");
    check_frame(8, 16'o055555, "f_ld_new");

    // Reset in mid-shift while sr_clk and sr_data are high
    bus_wr(13'o17570, 16'o007777, 1'b0, 1'b1, "pre_rst");
    repeat (46) @(negedge clk);
    check("mid_clk_high", {30'd0, sr_clk, sr_data}, 32'd3);
    base = fr_val.size();
    #2 reset_n = 1'b0;
    #1 check("abort_outs", {28'd0, busy, sr_clk, sr_data, sr_latch}, 32'd0);
    check("abort_display", 32'(display), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    wait_frames(base + 1, "f_after_rst");
    check_frame(base, 16'o000000, "f_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dr_regs.md
# dr_regs

Display register (DR) write-side slave on the iopage bus at 17777570, paired with the read-only switch register at the same address. Captures word and byte writes into a 16-bit display latch and serialises every new value MSB-first to an external shift-register LED chain (595-style: data, shift clock, latch strobe). Sits on the iopage bus beside the other `*_regs` slaves; its serial pins go to the front-panel lights.

## Interface
- `CLK_DIV`, 4, clk cycles per half-period of `sr_clk` and per `sr_latch` pulse; legal range 1..255.
- `clk`  in  1  system clock, all state on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iopage_addr`  in  13  iopage word/byte address.
- `data_in`  in  16  write data. Byte lanes: [7:0] for even, [15:8] for odd address.
- `iopage_rd`  in  1  read strobe. Ignored; the switch register owns reads.
- `iopage_wr`  in  1  write strobe, one cycle per access.
- `iopage_byte_op`  in  1  byte access qualifier.
- `decode`  out  1  `iopage_wr` & `iopage_addr[12:1]` == 13'o17570[12:1]. Combinational. Never asserted on reads.
- `display`  out  16  current display latch, for the panel and debug.
- `sr_data`  out  1  serial data, MSB first.
- `sr_clk`  out  1  serial shift clock; external device samples on rising edge.
- `sr_latch`  out  1  parallel-load strobe, high for CLK_DIV cycles.
- `busy`  out  1  a frame is in progress (state != IDLE).

## Operation
- Write with `decode` high and `iopage_byte_op` low: `display` <= `data_in`.
- Byte write, addr[0]=0: `display[7:0]` <= `data_in[7:0]`. Addr[0]=1: `display[15:8]` <= `data_in[15:8]`. The other byte is unchanged.
- Any decoded write sets `pending`. Writes to any other address, and all reads, do nothing.
- FSM has three states:
  - IDLE: if `pending`, load `shreg` <= `display`, clear `pending`, put `sr_data` = `display[15]`, go to SHIFT.
  - SHIFT: `div` counts CLK_DIV cycles per phase. Phase 0 holds `sr_clk` low. Phase 1 holds `sr_clk` high. At the end of phase 1, `sr_clk` falls and `shreg` shifts left. Moves to the next bit, or to LATCH after bit 0.
  - LATCH: `sr_data`=0 and `sr_latch`=1 for CLK_DIV cycles, then IDLE.
- A write in the same cycle as the IDLE load: `pending` stays set (set wins over clear), and the snapshot takes the pre-write value.
- Writes during SHIFT/LATCH update `display` immediately and set `pending`. Multiple writes coalesce into one following frame that carries the latest value. The frame in flight is never altered.
- Reset values:
  - `display`=0, `pending`=1, so a clearing frame is sent after reset.
  - State IDLE, `div`=0, bit count 0.
  - `sr_clk`=`sr_data`=`sr_latch`=`busy`=0.
- Reset asserted mid-frame aborts asynchronously: all serial outputs go low at once and the frame is lost. After release, the post-reset frame of zeros follows.
- Bit counter is 4 bits and is done at 15. `div` width is 8 bits.

## Timing
- `decode` is combinational, same cycle as `iopage_wr`.
- `display` updates at the posedge sampling the write (E0). `pending` also sets at E0.
- The frame starts at E1: `busy`=1, `sr_data`=bit 15.
- For bit k (k=15..0, j=15-k):
  - `sr_clk` rises at E1+(2j+1)·CLK_DIV.
  - `sr_clk` falls at E1+(2j+2)·CLK_DIV.
- `sr_data` changes only on a falling `sr_clk` edge, or at frame start. This gives CLK_DIV cycles of setup and hold.
- `sr_latch` is high from E1+32·CLK_DIV to E1+33·CLK_DIV.
- `busy` falls at E1+33·CLK_DIV. A pending follow-up frame starts one cycle later.
- CLK_DIV=4: a frame is 132 busy cycles, with latch rising at E1+128.

## Structure
- Shared package `pdp11_iopage_pkg`: constant `DR_ADDR` = 13'o17570 (shared with the switch register), and the FSM state enum {IDLE, SHIFT, LATCH}.
- Sub-module `dr_shift_out`: generic serializer with `start`/`busy`/16-bit `din`, parameter CLK_DIV. `dr_regs` keeps the decode, byte merge and `pending` logic.

## Test plan
- Reset release, then no writes: one frame of 16 zero bits. `sr_latch` pulse at E1+128 (CLK_DIV=4).
- Word write 16'o123456 to 17570:
  - `decode`=1 for one cycle; `display`=123456.
  - Serial bits sampled on `sr_clk` rise = 1010011100101110.
- Byte writes from `display`=0:
  - 17570, `data_in`=16'o177777 → `display`=16'o000377.
  - Then 17571, `data_in`=16'o125252 → `display`=16'o125377.
- Write to 17572, and a read at 17570: `decode`=0, `display` unchanged, no frame.
- Writes of 16'o1, then 16'o2, then 16'o3 during a frame:
  - The current frame completes unchanged.
  - Exactly one following frame, carrying 16'o3.
- Write at the IDLE load cycle, then `reset_n` low mid-SHIFT:
  - Two frames result: the old value, then the new one.
  - On reset: outputs are 0 immediately, and a zero frame follows release.
